dsp_mac_sequencer: RTL
======================

Name: dsp_mac_sequencer

Overview:
- Sequences one DSP48A1 slice as a streaming multiply-accumulate (dot-product) engine.
- Accepts a command with an operand count, then streams A/B operand pairs into the slice over a valid/ready handshake.
- Drives the slice's OPMODE and clock enables, tracks the 3-stage pipeline, and returns the 48-bit accumulated P on a result handshake.
- Sits between the command/operand source and the slice. Supported slice configuration: A0REG=0, B0REG=0, A1REG=1, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT="DIRECT", CARRYINSEL="OPMODE5".

Parameters:
- LEN_W, 8, width of the operand-count field; max run length 2^LEN_W-1.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- start_valid  in  1  command valid.
- start_ready  out  1  command ready; high only in IDLE.
- start_len  in  LEN_W  number of operand pairs in the run.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand ready; high only in LOAD.
- in_a  in  18  operand A, unsigned.
- in_b  in  18  operand B, unsigned.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted.
- res_data  out  48  accumulated sum.
- busy  out  1  high in any state other than IDLE.
- dsp_A  out  18  to slice A.
- dsp_B  out  18  to slice B.
- dsp_OPMODE  out  8  to slice OPMODE; slice CEOPMODE is tied high.
- dsp_CEA  out  1  to slice CEA.
- dsp_CEB  out  1  to slice CEB.
- dsp_CEM  out  1  to slice CEM.
- dsp_CEP  out  1  to slice CEP.
- dsp_P  in  48  from slice P.

Behaviour:
- Reset, async while RST_N=0:
  - state=IDLE.
  - All outputs 0, except start_ready=1.
  - Pipeline valid/first tags cleared; counter=0; res_data=0.
  - Reset mid-run abandons the run. Slice registers are not reset by this block, but CEP stays low until the next run's first product.
- States: IDLE, LOAD, DRAIN, RESULT.
- IDLE:
  - start fire (start_valid & start_ready) with start_len>0: latch count, go to LOAD.
  - start_len=0: go directly to RESULT with res_data=0.
- LOAD:
  - in_ready=1. Fire = in_valid & in_ready.
  - dsp_A=in_a and dsp_B=in_b, combinational pass-through.
  - dsp_CEA=dsp_CEB=fire.
  - Each fire decrements the count. The fire that brings the count to 0 moves the block to DRAIN.
  - in_valid gaps are allowed at any point; no CE pulses occur in gap cycles.
- Pipeline tags: v1/f1 are registered from fire and "is first operand of run"; v2/f2 are registered from v1/f1.
  - dsp_CEM = v1.
  - dsp_OPMODE is driven one cycle ahead for the OPMODE register:
    - 8'h01 (X=M, Z=0) when v1 & f1.
    - 8'h09 (X=M, Z=P) otherwise.
    - Bits 7,6,5,4 are always 0: add, no carry, no pre-adder.
  - dsp_CEP = v2. P loads only with valid products, so P holds through input gaps.
- DRAIN: wait until v1=v2=0, then capture dsp_P into res_data and go to RESULT.
- RESULT:
  - res_valid=1; res_data stable until res_ready.
  - On res_valid & res_ready, go to IDLE next cycle. The next start is acceptable the following cycle; there is no same-cycle overlap.
- Latency: if the last operand fires in cycle t, P updates at the end of t+2, res_data is captured at the end of t+3, and res_valid is high from t+4.
- Arithmetic:
  - Unsigned 18x18 products, accumulated mod 2^48 in the slice.
  - The first product of each run overwrites P (Z=0); no P reset is required between runs.
- start_valid held in non-IDLE states is ignored (start_ready=0). in_valid outside LOAD is ignored (in_ready=0).

Test Plan:
- Sum of products: start_len=3; pairs (2,3),(4,5),(6,7) sent back-to-back at t=1..3 -> res_valid rises at t=7, res_data=68; OPMODE sequence seen by the slice is 01,09,09.
- Input gaps: same data with in_valid low for 2 cycles between each pair -> res_data=68; dsp_CEA/dsp_CEP pulse exactly 3 times each.
- Zero length: start_len=0 -> no CE pulses, res_valid next cycle, res_data=0.
- Back-to-back runs with backpressure:
  - Run 1: len=2, (0x3FFFF,0x3FFFF) x2 -> 0x1_FFFF0_0002.
  - res_ready held low 5 cycles -> res_data stable.
  - Run 2: len=1, (1,1) -> 1, proving the first product overwrites P.
- Reset mid-run: RST_N low during LOAD after 2 of 4 operands -> all outputs 0 immediately, start_ready=1.
- Reset recovery: a fresh run with len=1, (3,3) after the mid-run reset -> res_data=9.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// Streams A/B operand pairs into a DSP48A1 slice configured as a multiply-accumulate
// engine, tracks its M/P pipeline and hands back the 48-bit dot product.
module dsp_mac_sequencer #(
  parameter int LEN_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [LEN_W-1:0] start_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic             busy,
  output logic [17:0]      dsp_A,
  output logic [17:0]      dsp_B,
  output logic [7:0]       dsp_OPMODE,
  output logic             dsp_CEA,
  output logic             dsp_CEB,
  output logic             dsp_CEM,
  output logic             dsp_CEP,
  input  logic [47:0]      dsp_P
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, RESULT} state_t;

  localparam logic [7:0] OPM_FIRST = 8'h01;  // X=M, Z=0
  localparam logic [7:0] OPM_ACC   = 8'h09;  // X=M, Z=P

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] count_reg, count_next;
  logic             first_reg, first_next;
  logic [47:0]      res_data_reg, res_data_next;
  logic             v1_reg, f1_reg, v2_reg;
  logic             start_fire, in_fire, res_fire;

  assign start_ready = (state_reg == IDLE);
  assign in_ready    = (state_reg == LOAD);
  assign res_valid   = (state_reg == RESULT);
  assign busy        = (state_reg != IDLE);

  assign start_fire = start_valid & start_ready;
  assign in_fire    = in_valid & in_ready;
  assign res_fire   = res_valid & res_ready;

  // Operands go straight to the slice's A1/B1 registers, gated by the fire strobe.
  assign dsp_A   = in_ready ? in_a : '0;
  assign dsp_B   = in_ready ? in_b : '0;
  assign dsp_CEA = in_fire;
  assign dsp_CEB = in_fire;
  assign dsp_CEM = v1_reg;
  assign dsp_CEP = v2_reg;

  // OPMODE is registered in the slice alongside M, so the choice follows the stage-1 tag.
  always_comb begin
    dsp_OPMODE = 8'h00;
    if (busy) begin
      dsp_OPMODE = (v1_reg && f1_reg) ? OPM_FIRST : OPM_ACC;
    end
  end

  assign res_data = res_data_reg;

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    first_next    = first_reg;
    res_data_next = res_data_reg;
    case (state_reg)
      IDLE: begin
        if (start_fire) begin
          if (start_len != '0) begin
            count_next = start_len;
            first_next = 1'b1;
            state_next = LOAD;
          end else begin
            res_data_next = '0;
            state_next    = RESULT;
          end
        end
      end
      LOAD: begin
        if (in_fire) begin
          count_next = count_reg - LEN_W'(1);
          first_next = 1'b0;
          if (count_reg == LEN_W'(1)) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Both pipeline stages empty means P holds the final sum.
        if (!v1_reg && !v2_reg) begin
          res_data_next = dsp_P;
          state_next    = RESULT;
        end
      end
      RESULT: begin
        if (res_fire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      first_reg    <= 1'b0;
      res_data_reg <= '0;
      v1_reg       <= 1'b0;
      f1_reg       <= 1'b0;
      v2_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      first_reg    <= first_next;
      res_data_reg <= res_data_next;
      v1_reg       <= in_fire;
      f1_reg       <= in_fire & first_reg;
      v2_reg       <= v1_reg;
    end
  end

endmodule
